// File: rtl/nand_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_seq_pkg
// Description : Shared opcode/state enums and per-opcode NAND step counts.
// Revision    : 1.0 - initial release
// ============================================================================
package nand_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOT = 2'd0,
        OP_AND = 2'd1,
        OP_OR  = 2'd2,
        OP_XOR = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // NAND evaluations needed per result bit, indexed by opcode
    localparam logic [3:0][2:0] STEPS = {3'd4, 3'd3, 3'd2, 3'd1};

endpackage
`default_nettype wire

// File: rtl/myNAND.sv
`default_nettype none
// ============================================================================
// Module      : myNAND
// Description : Single 1-bit NAND gate shared by the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module myNAND (
    input  logic inA,
    input  logic inB,
    output logic out
);

    assign out = ~(inA & inB);

endmodule
`default_nettype wire

// File: rtl/nand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nand_sequencer
// Description : Bit-serial NOT/AND/OR/XOR unit built from one shared NAND gate.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_sequencer
    import nand_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic [15:0]      nand_evals
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         step_q, step_d;
    logic               t_q, t_d, u_q, u_d, v_q, v_d;
    logic [15:0]        evals_q, evals_d;

    logic               a_bit, b_bit, last_step;
    logic               nand_a, nand_b, nand_y;

    myNAND u_nand (
        .inA (nand_a),
        .inB (nand_b),
        .out (nand_y)
    );

    assign a_bit     = a_q[idx_q];
    assign b_bit     = b_q[idx_q];
    assign last_step = ({1'b0, step_q} == (STEPS[op_q] - 3'd1));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        step_d   = step_q;
        t_d      = t_q;
        u_d      = u_q;
        v_d      = v_q;
        result_d = result_q;
        evals_d  = evals_q;
        nand_a   = 1'b0;
        nand_b   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    op_d    = op_t'(op);
                    a_d     = opA;
                    b_d     = opB;
                    idx_d   = '0;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                evals_d = evals_q + 16'd1;
                // Operand mux: choose the NAND inputs for this op/step pair
                case (op_q)
                    OP_NOT: begin nand_a = a_bit; nand_b = a_bit; end
                    OP_AND: begin
                        if (step_q == 2'd0) begin nand_a = a_bit; nand_b = b_bit; end
                        else                begin nand_a = t_q;   nand_b = t_q;   end
                    end
                    OP_OR: begin
                        if (step_q == 2'd0)      begin nand_a = a_bit; nand_b = a_bit; end
                        else if (step_q == 2'd1) begin nand_a = b_bit; nand_b = b_bit; end
                        else                     begin nand_a = t_q;   nand_b = u_q;   end
                    end
                    default: begin
                        if (step_q == 2'd0)      begin nand_a = a_bit; nand_b = b_bit; end
                        else if (step_q == 2'd1) begin nand_a = a_bit; nand_b = t_q;   end
                        else if (step_q == 2'd2) begin nand_a = b_bit; nand_b = t_q;   end
                        else                     begin nand_a = u_q;   nand_b = v_q;   end
                    end
                endcase

                if (last_step) begin
                    result_d[idx_q] = nand_y;
                    step_d          = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    step_d = step_q + 2'd1;
                    case (step_q)
                        2'd0:    t_d = nand_y;
                        2'd1:    u_d = nand_y;
                        default: v_d = nand_y;
                    endcase
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_NOT;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            step_q   <= '0;
            t_q      <= 1'b0;
            u_q      <= 1'b0;
            v_q      <= 1'b0;
            result_q <= '0;
            evals_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            step_q   <= step_d;
            t_q      <= t_d;
            u_q      <= u_d;
            v_q      <= v_d;
            result_q <= result_d;
            evals_q  <= evals_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign result       = result_q;
    assign nand_evals   = evals_q;

endmodule
`default_nettype wire

// File: tb/tb_nand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_sequencer
// Description : Self-checking bench for nand_sequencer against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_sequencer;

    localparam int W = 8;
    localparam logic [31:0] MASK = (W == 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [1:0]   op;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] result;
    logic [15:0]  nand_evals;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] evals_m = 16'd0;

    nand_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .opA          (opA),
        .opB          (opB),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .nand_evals   (nand_evals)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: NAND gate counts per bit from the opcode table
    function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'd0:    return ~a & MASK;
            2'd1:    return (a & b) & MASK;
            2'd2:    return (a | b) & MASK;
            default: return (a ^ b) & MASK;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o);
        int gates [4] = '{1, 2, 3, 4};
        return W * gates[o];
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_r;
        int          exp_lat;
        int          cnt;
        bit          busy_rdy;
        exp_r   = model_res(o, a & MASK, b & MASK);
        exp_lat = model_lat(o);
        busy_rdy = 1'b0;
        start_valid = 1'b1;
        op  = o;
        opA = a[W-1:0];
        opB = b[W-1:0];
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op  = 2'($urandom);
        opA = W'($urandom);
        opB = W'($urandom);
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            if (result_valid === 1'b1 || cnt > 200) break;
            if (start_ready !== 1'b0) busy_rdy = 1'b1;
            start_valid  = 1'($urandom);
            result_ready = 1'($urandom);
            op  = 2'($urandom);
            opA = W'($urandom);
            opB = W'($urandom);
        end
        result_ready = 1'b0;
        if (cnt > 200) begin
            chk("timeout", 32'd0, 32'd1);
            start_valid = 1'b0;
            return;
        end
        evals_m = evals_m + 16'(exp_lat);
        chk("latency", cnt, exp_lat);
        chk("busy_ready", {31'd0, busy_rdy}, 32'd0);
        chk("result", {{(32-W){1'b0}}, result}, exp_r);
        chk("done_ready", {31'd0, start_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, result_valid}, 32'd1);
            chk("hold_result", {{(32-W){1'b0}}, result}, exp_r);
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        chk("idle_ready", {31'd0, start_ready}, 32'd1);
        chk("idle_valid", {31'd0, result_valid}, 32'd0);
        chk("idle_result", {{(32-W){1'b0}}, result}, exp_r);
        chk("evals", {16'd0, nand_evals}, {16'd0, evals_m});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  {31'd0, start_ready},  32'd1);
        chk({tag, "_valid"},  {31'd0, result_valid}, 32'd0);
        chk({tag, "_result"}, {{(32-W){1'b0}}, result}, 32'd0);
        chk({tag, "_evals"},  {16'd0, nand_evals},   32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_valid = 1'b0;
        result_ready = 1'b0;
        op = 2'd0;
        opA = '0;
        opB = '0;
        #1;
        chk_reset_vals("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(2'd0, 32'h5A, 32'h00, 0);
        do_op(2'd1, 32'hF0, 32'h3C, 5);
        do_op(2'd2, 32'hF0, 32'h0F, 1);
        do_op(2'd3, 32'hAA, 32'hFF, 0);
        chk("evals80", {16'd0, nand_evals}, 32'd80);

        // Abort an XOR mid-run with an asynchronous reset
        start_valid = 1'b1;
        op  = 2'd3;
        opA = W'(8'hAA);
        opB = W'(8'h55);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        evals_m = 16'd0;
        chk_reset_vals("arst");
        @(negedge clk);
        rst = 1'b0;
        do_op(2'd0, 32'h00, 32'h00, 0);
        chk("not00", {{(32-W){1'b0}}, result}, 32'hFF & MASK);

        for (int k = 0; k < 20; k++) begin
            do_op(2'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
